// File: rtl/marquee_scroller.sv
// marquee_scroller: rotates a latched hex message one digit per prescaled step and shows the top DIGITS nibbles.
// Loop or single-pass scrolling with pause, stop and load; async active-low clear.
module marquee_scroller #(
    parameter int DIGITS     = 4,
    parameter int MSG_DIGITS = 8,
    parameter int DIV        = 1
) (
    input  logic                    clk3hz,
    input  logic                    clr,
    input  logic                    load,
    input  logic [4*MSG_DIGITS-1:0] msg,
    input  logic                    dir,
    input  logic                    mode,
    input  logic                    pause,
    input  logic                    stop,
    output logic [4*DIGITS-1:0]     dataBus,
    output logic                    busy,
    output logic                    done
);
    localparam int W  = 4 * MSG_DIGITS;
    localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
    localparam int SW = $clog2(MSG_DIGITS);

    typedef enum logic [1:0] {IDLE, SCROLL, DONE} state_t;

    state_t          state;
    logic [W-1:0]    msg_r;
    logic            mode_r;
    logic [PW-1:0]   pcnt;
    logic [SW-1:0]   scnt;
    logic            last;

    assign dataBus = msg_r[W-1 -: 4*DIGITS];
    assign last    = scnt == SW'(MSG_DIGITS - 1);

    always_ff @(posedge clk3hz or negedge clr) begin
        if (!clr) begin
            state  <= IDLE;
            msg_r  <= '0;
            mode_r <= 1'b0;
            pcnt   <= '0;
            scnt   <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else if (load) begin
            state  <= SCROLL;
            msg_r  <= msg;
            mode_r <= mode;
            pcnt   <= '0;
            scnt   <= '0;
            busy   <= 1'b1;
            done   <= 1'b0;
        end else if (stop && state != IDLE) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else if (state == SCROLL && !pause) begin
            if (pcnt == PW'(DIV - 1)) begin
                pcnt  <= '0;
                msg_r <= dir ? {msg_r[3:0], msg_r[W-1:4]} : {msg_r[W-5:0], msg_r[W-1:W-4]};
                scnt  <= last ? '0 : scnt + SW'(1);
                // Single pass ends on the rotation that restores the loaded message
                if (last && mode_r) begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
            end else begin
                pcnt <= pcnt + PW'(1);
            end
        end
    end
endmodule

// File: doc/marquee_scroller.md
# marquee_scroller

Parametrised nibble-rotating marquee for the seven-segment display path. It latches a message of `MSG_DIGITS` hex digits and rotates it one digit per step, left or right. It drives the top `DIGITS` digits to the display driver. Supports loop or single-pass mode, pause, stop, and a step prescaler, so one instance serves any display width and message length.

## Interface

- `DIGITS`, 4: number of displayed hex digits. Requires 1 ≤ `DIGITS` ≤ `MSG_DIGITS`.
- `MSG_DIGITS`, 8: message length in hex digits. Requires `MSG_DIGITS` ≥ 2.
- `DIV`, 1: active clock cycles per step. Requires `DIV` ≥ 1.
- `clk3hz` input 1: the single clock; all state updates on its rising edge.
- `clr` input 1: reset, asynchronous, active-low.
- `load` input 1: one-cycle pulse; latches `msg` and `mode` and starts scrolling.
- `msg` input 4*`MSG_DIGITS`: message; digit 0 is in the MS nibble.
- `dir` input 1: step direction; 0 = rotate left, 1 = rotate right.
- `mode` input 1: 0 = loop forever, 1 = single pass.
- `pause` input 1: level; freezes scrolling while high.
- `stop` input 1: one-cycle pulse; abort to IDLE, display frozen.
- `dataBus` output 4*`DIGITS`: top `DIGITS` nibbles of the message register.
- `busy` output 1: high in SCROLL.
- `done` output 1: high in DONE.

## Operation

- Registers:
  - `msg_r`: W = 4*`MSG_DIGITS` bits.
  - `mode_r`.
  - Prescaler `pcnt`: counts 0..`DIV`-1.
  - Step counter `scnt`: counts 0..`MSG_DIGITS`-1.
  - State: IDLE, SCROLL, DONE.
- `dataBus` = `msg_r[W-1 : W-4*DIGITS]`.
- Rotate left: `msg_r` ← {`msg_r[W-5:0]`, `msg_r[W-1:W-4]`}.
- Rotate right: `msg_r` ← {`msg_r[3:0]`, `msg_r[W-1:4]`}.
- `dir` is sampled at every step edge, so a direction change mid-scroll takes effect on the next step.
- Step condition: state = SCROLL, `pause` = 0, and `pcnt` = `DIV`-1. On a step:
  - `pcnt` ← 0.
  - Rotate `msg_r`.
  - `scnt` ← (`scnt`+1) mod `MSG_DIGITS`.
- Otherwise, in SCROLL with `pause` = 0: `pcnt` increments. With `pause` = 1, `pcnt`, `scnt` and `msg_r` hold.
- Transitions, in priority order:
  1. `load` = 1 in any state → SCROLL. `msg_r` ← `msg`, `mode_r` ← `mode`, `pcnt` ← 0, `scnt` ← 0. Any pending step that cycle is discarded.
  2. `stop` = 1 in SCROLL or DONE → IDLE. `msg_r` holds.
  3. In SCROLL, a step with `scnt` = `MSG_DIGITS`-1 and `mode_r` = 1 → DONE. The rotation is still applied, so `msg_r` equals the loaded message again.
  4. In SCROLL with `mode_r` = 0: `scnt` wraps to 0 and scrolling continues indefinitely.
- IDLE and DONE ignore `pause` and `dir`. Both hold `msg_r`.
- `stop` in IDLE has no effect.

## Timing

- Reset (`clr` = 0), effective immediately without a clock:
  - state = IDLE.
  - `msg_r` = 0, so `dataBus` = 0.
  - `busy` = 0, `done` = 0.
  - `pcnt` = 0, `scnt` = 0, `mode_r` = 0.
- Release of `clr` is synchronous to the design; the first active edge may be the one following release.
- `busy` and `done` decode the state register; they change on the same edge as the state.
- Load latency: `load` sampled high at edge N → `dataBus` shows `msg` digits after edge N, and `busy` = 1.
- Step timing: the first step occurs at edge N+`DIV`. Later steps follow every `DIV` unpaused cycles. Paused cycles extend the interval one-for-one.
- Single pass: `done` rises at edge N+`MSG_DIGITS`*`DIV` (no pause). At that same edge `busy` falls and `dataBus` equals the initial view.
- `load` and `stop` in the same cycle: `load` wins.
- `load` while `pause` = 1: the load is still taken. Scrolling starts once `pause` falls.
- `clr` mid-scroll aborts everything; the message is lost.

## Test plan

Default instance (`DIGITS`=4, `MSG_DIGITS`=8, `DIV`=1) unless stated; `msg` = 32'h12345678 throughout.

- Reset: assert `clr` = 0 with no clock edge → `dataBus` = 16'h0000, `busy` = 0, `done` = 0 at once. Hold and pulse `load` → no change.
- Loop, left: `load` with `dir` = 0, `mode` = 0 → after the load edge `dataBus` = 1234. Next edges give 2345, 3456, 4567, 5678, 6781, 7812, 8123, then 1234 again. `busy` stays 1 and `done` stays 0.
- Right and direction change: `load` with `dir` = 1 → 1234, then 8123, 7812. Set `dir` = 0 → next step gives 8123.
- Single pass: `mode` = 1 → after exactly 8 steps `dataBus` = 1234, `done` = 1, `busy` = 0. Further cycles leave it unchanged. `stop` → IDLE with `done` = 0 and `dataBus` still 1234.
- Prescale, pause and priority (`DIV` = 3): steps fall every 3rd edge. Hold `pause` for 5 cycles mid-interval → next step is delayed by exactly 5 cycles. Pulse `load` (`msg` = 32'hABCDEF01) and `stop` in the same cycle → `dataBus` = ABCD, `busy` = 1, `pcnt` restarts.
- Async abort: drop `clr` between edges mid-scroll → `dataBus` = 0 and `busy` = 0 before the next edge. After release, `dataBus` stays 0 until a `load`.
